// File: rtl/pid_ctrl_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pid_ctrl_pipe                                                  |
// | Brief   : 3-stage pipelined PID heading controller producing clamped     |
// |           left/right motor speeds from signed heading error samples.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pid_ctrl_pipe #(
  parameter int ERR_W   = 12,
  parameter int SAT_W   = 10,
  parameter int FRWRD_W = 10,
  parameter int P_COEFF = 16,
  parameter int D_COEFF = 7,
  parameter int I_SHIFT = 6,
  parameter int INT_W   = 15,
  parameter int D_DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    moving,
  input  logic                    err_vld,
  input  logic signed [ERR_W-1:0] error,
  input  logic [FRWRD_W-1:0]      frwrd,
  output logic [FRWRD_W:0]        lft_spd,
  output logic [FRWRD_W:0]        rght_spd,
  output logic                    spd_vld
);

  localparam int c_W = 32;
  localparam logic signed [ERR_W-1:0] c_ERR_MAX = ERR_W'((2 ** (SAT_W - 1)) - 1);
  localparam logic signed [ERR_W-1:0] c_ERR_MIN = ERR_W'(-(2 ** (SAT_W - 1)));
  localparam logic signed [SAT_W-1:0] c_SAT_MAX = {1'b0, {(SAT_W-1){1'b1}}};
  localparam logic signed [SAT_W-1:0] c_SAT_MIN = {1'b1, {(SAT_W-1){1'b0}}};
  localparam logic signed [SAT_W:0]   c_D_HI    = (SAT_W+1)'(127);
  localparam logic signed [SAT_W:0]   c_D_LO    = (SAT_W+1)'(-128);
  localparam logic signed [c_W-1:0]   c_SPD_MAX = c_W'((2 ** FRWRD_W) - 1);

  // stage 1 registers
  logic                    r1_vld;
  logic                    r1_mov;
  logic signed [SAT_W-1:0] r1_err;
  logic [FRWRD_W-1:0]      r1_frwrd;

  // stage 2 registers and persistent state
  logic                    r2_vld;
  logic                    r2_mov;
  logic signed [c_W-1:0]   r2_p;
  logic signed [c_W-1:0]   r2_d;
  logic [FRWRD_W-1:0]      r2_frwrd;
  logic signed [INT_W-1:0] r_integ;
  logic signed [SAT_W-1:0] r_hist [D_DEPTH];

  logic signed [SAT_W-1:0] w_err_sat;
  logic signed [INT_W:0]   w_int_sum;
  logic                    w_int_ovf;
  logic signed [SAT_W:0]   w_diff;
  logic signed [7:0]       w_dsat;
  logic signed [c_W-1:0]   w_p;
  logic signed [c_W-1:0]   w_d;
  logic signed [c_W-1:0]   w_pid;
  logic signed [c_W-1:0]   w_adj;
  logic signed [c_W-1:0]   w_fr;
  logic signed [c_W-1:0]   w_l;
  logic signed [c_W-1:0]   w_r;

  function automatic logic [FRWRD_W:0] clamp_spd(input logic signed [c_W-1:0] v);
    if (v < 0)
      return '0;
    else if (v > c_SPD_MAX)
      return c_SPD_MAX[FRWRD_W:0];
    else
      return v[FRWRD_W:0];
  endfunction

  always_comb begin
    w_err_sat = error[SAT_W-1:0];
    if (error > c_ERR_MAX)
      w_err_sat = c_SAT_MAX;
    else if (error < c_ERR_MIN)
      w_err_sat = c_SAT_MIN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_vld   <= 1'b0;
      r1_mov   <= 1'b0;
      r1_err   <= '0;
      r1_frwrd <= '0;
    end else begin
      r1_vld <= err_vld;
      if (err_vld) begin
        r1_err   <= w_err_sat;
        r1_frwrd <= frwrd;
        r1_mov   <= moving;
      end
    end
  end

  // one guard bit detects signed overflow: top two bits disagree
  assign w_int_sum = (INT_W+1)'(r_integ) + (INT_W+1)'(r1_err);
  assign w_int_ovf = w_int_sum[INT_W] ^ w_int_sum[INT_W-1];
  assign w_diff    = (SAT_W+1)'(r1_err) - (SAT_W+1)'(r_hist[D_DEPTH-1]);

  always_comb begin
    w_dsat = 8'(w_diff);
    if (w_diff > c_D_HI)
      w_dsat = 8'sd127;
    else if (w_diff < c_D_LO)
      w_dsat = -8'sd128;
  end

  assign w_p = c_W'(r1_err) * c_W'(P_COEFF);
  assign w_d = c_W'(w_dsat) * c_W'(D_COEFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_vld   <= 1'b0;
      r2_mov   <= 1'b0;
      r2_p     <= '0;
      r2_d     <= '0;
      r2_frwrd <= '0;
      r_integ  <= '0;
      for (int i = 0; i < D_DEPTH; i++)
        r_hist[i] <= '0;
    end else begin
      r2_vld <= r1_vld;
      if (r1_vld) begin
        r2_p      <= w_p;
        r2_d      <= w_d;
        r2_frwrd  <= r1_frwrd;
        r2_mov    <= r1_mov;
        r_hist[0] <= r1_err;
        for (int i = 1; i < D_DEPTH; i++)
          r_hist[i] <= r_hist[i-1];
      end
      // a live stop wins over any integration in the same cycle
      if (!moving)
        r_integ <= '0;
      else if (r1_vld && !w_int_ovf)
        r_integ <= w_int_sum[INT_W-1:0];
    end
  end

  assign w_pid = (r2_p >>> 1) + (c_W'(r_integ) >>> I_SHIFT) + r2_d;
  assign w_adj = w_pid >>> 3;
  assign w_fr  = c_W'(r2_frwrd);
  assign w_l   = w_fr + w_adj;
  assign w_r   = w_fr - w_adj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_spd  <= '0;
      rght_spd <= '0;
      spd_vld  <= 1'b0;
    end else begin
      spd_vld <= r2_vld;
      if (r2_vld) begin
        lft_spd  <= r2_mov ? clamp_spd(w_l) : '0;
        rght_spd <= r2_mov ? clamp_spd(w_r) : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pid_ctrl_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_pid_ctrl_pipe                                               |
// | Brief   : Directed self-checking bench for pid_ctrl_pipe at defaults.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pid_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        moving;
  logic        err_vld;
  logic [11:0] error;
  logic [9:0]  frwrd;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic        spd_vld;

  int errors = 0;
  int checks = 0;

  pid_ctrl_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .moving   (moving),
    .err_vld  (err_vld),
    .error    (error),
    .frwrd    (frwrd),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .spd_vld  (spd_vld)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n   = 1'b0;
    moving  = 1'b1;
    err_vld = 1'b0;
    error   = '0;
    frwrd   = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      err_vld = ~err_vld;
      moving  = ~moving;
      error   = 12'($urandom);
      frwrd   = 10'($urandom);
      tick();
      checks++;
      if (spd_vld !== 1'b0 || lft_spd !== 11'h0 || rght_spd !== 11'h0) begin
        errors++;
        $display("FAIL reset cyc%0d: vld=%b l=%h r=%h, need 0/000/000", i, spd_vld, lft_spd, rght_spd);
      end
    end
  endtask

  task automatic test_basic;
    do_reset();
    frwrd = 10'h100; error = 12'h010; err_vld = 1'b1;
    tick();
    err_vld = 1'b0;
    checks++;
    if (spd_vld !== 1'b0) begin errors++; $display("FAIL basic_lat1: vld=%b need 0", spd_vld); end
    tick();
    checks++;
    if (spd_vld !== 1'b0) begin errors++; $display("FAIL basic_lat2: vld=%b need 0", spd_vld); end
    tick();
    checks++;
    if (spd_vld !== 1'b1 || lft_spd !== 11'h11E || rght_spd !== 11'h0E2) begin
      errors++;
      $display("FAIL basic_out: vld=%b l=%h r=%h, need 1/11e/0e2", spd_vld, lft_spd, rght_spd);
    end
    tick();
    tick();
    checks++;
    if (spd_vld !== 1'b0 || lft_spd !== 11'h11E || rght_spd !== 11'h0E2) begin
      errors++;
      $display("FAIL basic_hold: vld=%b l=%h r=%h, need 0/11e/0e2", spd_vld, lft_spd, rght_spd);
    end
  endtask

  task automatic test_sat_pos;
    do_reset();
    frwrd = 10'h300; error = 12'h7FF; err_vld = 1'b1;
    tick();
    err_vld = 1'b0;
    tick();
    tick();
    checks++;
    if (spd_vld !== 1'b1 || lft_spd !== 11'h3FF || rght_spd !== 11'h091) begin
      errors++;
      $display("FAIL sat_pos: vld=%b l=%h r=%h, need 1/3ff/091", spd_vld, lft_spd, rght_spd);
    end
  endtask

  task automatic test_sat_neg;
    do_reset();
    frwrd = 10'h040; error = 12'hE00; err_vld = 1'b1;
    tick();
    err_vld = 1'b0;
    tick();
    tick();
    checks++;
    if (spd_vld !== 1'b1 || lft_spd !== 11'h000 || rght_spd !== 11'h2B1) begin
      errors++;
      $display("FAIL sat_neg: vld=%b l=%h r=%h, need 1/000/2b1", spd_vld, lft_spd, rght_spd);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    frwrd = 10'h100; err_vld = 1'b1; error = 12'h010;
    tick();
    error = 12'h020;
    tick();
    err_vld = 1'b0;
    tick();
    checks++;
    if (spd_vld !== 1'b1 || lft_spd !== 11'h11E || rght_spd !== 11'h0E2) begin
      errors++;
      $display("FAIL b2b_first: vld=%b l=%h r=%h, need 1/11e/0e2", spd_vld, lft_spd, rght_spd);
    end
    tick();
    checks++;
    if (spd_vld !== 1'b1 || lft_spd !== 11'h13C || rght_spd !== 11'h0C4) begin
      errors++;
      $display("FAIL b2b_second: vld=%b l=%h r=%h, need 1/13c/0c4", spd_vld, lft_spd, rght_spd);
    end
    tick();
    checks++;
    if (spd_vld !== 1'b0) begin errors++; $display("FAIL b2b_end: vld=%b need 0", spd_vld); end
  endtask

  // 511 per sample into a 15-bit integrator: freezes at 16352 after 32 samples
  task automatic test_windup;
    int integ, n, dterm, adj, el, er;
    do_reset();
    integ = 0; n = 0;
    frwrd = 10'h300; error = 12'h1FF; err_vld = 1'b1;
    for (int t = 0; t <= 42; t++) begin
      tick();
      if (t == 39) err_vld = 1'b0;
      if (t >= 2 && t <= 41) begin
        n++;
        if (integ + 511 <= 16383) integ = integ + 511;
        dterm = (n <= 3) ? 889 : 0;
        adj = (4088 + (integ >>> 6) + dterm) >>> 3;
        el = 768 + adj; if (el > 1023) el = 1023;
        er = 768 - adj; if (er < 0) er = 0;
        checks++;
        if (spd_vld !== 1'b1 || lft_spd !== 11'(el) || rght_spd !== 11'(er)) begin
          errors++;
          $display("FAIL windup n%0d: vld=%b l=%h r=%h, need 1/%h/%h", n, spd_vld, lft_spd, rght_spd, 11'(el), 11'(er));
        end
      end else if (t == 42) begin
        checks++;
        if (spd_vld !== 1'b0) begin errors++; $display("FAIL windup_end: vld=%b need 0", spd_vld); end
      end
    end
    checks++;
    if (lft_spd !== 11'h3FF || rght_spd !== 11'd226) begin
      errors++;
      $display("FAIL windup_frozen: l=%h r=%0d, need 3ff/226", lft_spd, rght_spd);
    end
  endtask

  task automatic test_moving;
    do_reset();
    frwrd = 10'h200; error = 12'h100; err_vld = 1'b1;
    tick();
    err_vld = 1'b0;
    tick();
    tick();
    checks++;
    if (spd_vld !== 1'b1 || lft_spd !== 11'h36F || rght_spd !== 11'h091) begin
      errors++;
      $display("FAIL mov_a: vld=%b l=%h r=%h, need 1/36f/091", spd_vld, lft_spd, rght_spd);
    end
    moving = 1'b0;
    tick();
    moving = 1'b1;
    err_vld = 1'b1;
    tick();
    err_vld = 1'b0;
    tick();
    tick();
    checks++;
    if (spd_vld !== 1'b1 || lft_spd !== 11'h36F || rght_spd !== 11'h091) begin
      errors++;
      $display("FAIL mov_clear: vld=%b l=%h r=%h, need 1/36f/091", spd_vld, lft_spd, rght_spd);
    end
    moving = 1'b0; err_vld = 1'b1;
    tick();
    moving = 1'b1; err_vld = 1'b0;
    tick();
    tick();
    checks++;
    if (spd_vld !== 1'b1 || lft_spd !== 11'h000 || rght_spd !== 11'h000) begin
      errors++;
      $display("FAIL mov_tag0: vld=%b l=%h r=%h, need 1/000/000", spd_vld, lft_spd, rght_spd);
    end
  endtask

  task automatic test_reset_midstream;
    do_reset();
    frwrd = 10'h100; error = 12'h010; err_vld = 1'b1;
    tick();
    err_vld = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (spd_vld !== 1'b0 || lft_spd !== 11'h0) begin
        errors++;
        $display("FAIL rst_mid cyc%0d: vld=%b l=%h, need 0/000", i, spd_vld, lft_spd);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; moving = 1'b1; err_vld = 1'b0; error = '0; frwrd = '0;
    test_reset();
    test_basic();
    test_sat_pos();
    test_sat_neg();
    test_back_to_back();
    test_windup();
    test_moving();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
